// File: rtl/mem_access.sv
// mem_access: memory-access stage between execute and writeback.
//
// Accepts one operation at a time from execute (ea/eb plus load/store
// controls), issues at most one data-bus transaction, and presents the
// result to writeback with a valid/ready handshake.
//
// Ports
//   clk, resetn                   clock, asynchronous active-low reset
//   in_valid / in_ready           execute handshake (in_ready only in IDLE)
//   ea, eb                        effective address / ALU result, store data
//   mem_rd, mem_wr                load / store (neither or both: pass-through)
//   mem_size, mem_sext            0 byte, 1 half, 2/3 word; load sign-extend
//   data_req, data_wr             bus request, write flag
//   data_size, data_addr          bus transfer size, bus address
//   data_wdata, data_wstrb        lane-replicated store data, byte strobes
//   data_addr_ok, data_data_ok    bus address accept, data complete
//   data_rdata                    bus read data
//   out_valid / out_ready         writeback handshake
//   out_data, out_exc             result, address-error flag
//
// Build option: define MEM_ALIGN_CHECK_EN to turn misaligned half/word
// accesses into an address-error result without touching the bus. When it
// is not defined, out_exc is tied low and misaligned accesses go to the bus
// with the address low bits cleared for the access size.
module mem_access (
  input  logic        clk,
  input  logic        resetn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] ea,
  input  logic [31:0] eb,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [1:0]  mem_size,
  input  logic        mem_sext,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  output logic [3:0]  data_wstrb,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_exc
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] ea_q, ea_d;
  logic [31:0] eb_q, eb_d;
  logic        ld_q, ld_d;
  logic        st_q, st_d;
  logic [1:0]  size_q, size_d;
  logic        sext_q, sext_d;
  logic [31:0] out_data_q, out_data_d;
  logic        take_exc;

  // Clear the address bits that must be zero for the transfer size.
  function automatic logic [31:0] align_addr(input logic [31:0] a, input logic [1:0] sz);
    case (sz)
      2'd0:    return a;
      2'd1:    return {a[31:1], 1'b0};
      default: return {a[31:2], 2'b00};
    endcase
  endfunction

  // Pick the addressed byte/half out of the bus word and extend it.
  function automatic logic [31:0] load_ext(input logic [31:0] rd, input logic [1:0] off,
                                           input logic [1:0] sz, input logic sx);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = rd[7:0];
      2'd1:    b = rd[15:8];
      2'd2:    b = rd[23:16];
      default: b = rd[31:24];
    endcase
    h = off[1] ? rd[31:16] : rd[15:0];
    case (sz)
      2'd0:    return sx ? {{24{b[7]}}, b} : {24'b0, b};
      2'd1:    return sx ? {{16{h[15]}}, h} : {16'b0, h};
      default: return rd;
    endcase
  endfunction

`ifdef MEM_ALIGN_CHECK_EN
  logic out_exc_q, out_exc_d;

  always_comb begin
    take_exc = 1'b0;
    if (mem_rd ^ mem_wr) begin
      if (mem_size == 2'd1)
        take_exc = ea[0];
      else if (mem_size[1])
        take_exc = (ea[1:0] != 2'b00);
    end
  end

  always_comb begin
    out_exc_d = out_exc_q;
    if (state_q == S_IDLE && in_valid)
      out_exc_d = take_exc;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) out_exc_q <= 1'b0;
    else         out_exc_q <= out_exc_d;
  end

  assign out_exc = out_exc_q;
`else
  assign take_exc = 1'b0;
  assign out_exc  = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    ea_d       = ea_q;
    eb_d       = eb_q;
    ld_d       = ld_q;
    st_d       = st_q;
    size_d     = size_q;
    sext_d     = sext_q;
    out_data_d = out_data_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          ea_d   = ea;
          eb_d   = eb;
          // rd and wr together is illegal and degrades to pass-through.
          ld_d   = mem_rd & ~mem_wr;
          st_d   = mem_wr & ~mem_rd;
          size_d = mem_size;
          sext_d = mem_sext;
          if ((mem_rd ^ mem_wr) && !take_exc) begin
            state_d = S_REQ;
          end else begin
            state_d    = S_DONE;
            out_data_d = ea;
          end
        end
      end
      S_REQ: begin
        if (data_addr_ok) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (data_data_ok) begin
          state_d    = S_DONE;
          out_data_d = ld_q ? load_ext(data_rdata, ea_q[1:0], size_q, sext_q) : ea_q;
        end
      end
      default: begin
        if (out_ready) state_d = S_IDLE;
      end
    endcase
  end

  // All state is cleared so every output reads zero while in reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      ea_q       <= '0;
      eb_q       <= '0;
      ld_q       <= 1'b0;
      st_q       <= 1'b0;
      size_q     <= 2'd0;
      sext_q     <= 1'b0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      ea_q       <= ea_d;
      eb_q       <= eb_d;
      ld_q       <= ld_d;
      st_q       <= st_d;
      size_q     <= size_d;
      sext_q     <= sext_d;
      out_data_q <= out_data_d;
    end
  end

  // Bus fields come straight from the latched operation, so they cannot
  // change while a request waits for data_addr_ok.
  always_comb begin
    data_wdata = eb_q;
    data_wstrb = 4'b0000;
    case (size_q)
      2'd0:    data_wdata = {4{eb_q[7:0]}};
      2'd1:    data_wdata = {2{eb_q[15:0]}};
      default: data_wdata = eb_q;
    endcase
    if (st_q) begin
      case (size_q)
        2'd0:    data_wstrb = 4'b0001 << ea_q[1:0];
        2'd1:    data_wstrb = 4'b0011 << {ea_q[1], 1'b0};
        default: data_wstrb = 4'b1111;
      endcase
    end
  end

  assign in_ready  = resetn && (state_q == S_IDLE);
  assign data_req  = (state_q == S_REQ);
  assign data_wr   = st_q;
  assign data_size = size_q;
  assign data_addr = align_addr(ea_q, size_q);
  assign out_valid = (state_q == S_DONE);
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_mem_access.sv
module tb_mem_access;

  logic        clk = 1'b0;
  logic        resetn;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] ea, eb;
  logic        mem_rd, mem_wr;
  logic [1:0]  mem_size;
  logic        mem_sext;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        out_valid, out_ready;
  logic [31:0] out_data;
  logic        out_exc;

  typedef struct packed {
    logic [31:0] d;
    logic        x;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   req_cycles = 0;
  int   r0;

  mem_access dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .ea(ea), .eb(eb), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_size(mem_size), .mem_sext(mem_sext),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_wstrb(data_wstrb),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_exc(out_exc)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: one comparison per completed writeback handshake.
  always @(negedge clk) begin
    if (resetn === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_output: got data 0x%08h with no pending expectation", out_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("out_data", out_data, e.d);
        check("out_exc", {31'b0, out_exc}, {31'b0, e.x});
      end
    end
  end

  always @(negedge clk) if (data_req === 1'b1) req_cycles++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Present one operation in IDLE; returns #1 after the accepting edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic rd,
                       input logic wr, input logic [1:0] sz, input logic sx);
    in_valid = 1'b1; ea = a; eb = b; mem_rd = rd; mem_wr = wr;
    mem_size = sz; mem_sext = sx;
    @(negedge clk);
    check("in_ready_idle", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    // Inputs are don't-care after acceptance; scramble them.
    in_valid = 1'b0; ea = $urandom; eb = $urandom; mem_rd = 1'b1; mem_wr = 1'b0;
    mem_size = 2'($urandom); mem_sext = ~sx;
  endtask

  // Drive a bus response from REQ through DONE; stray data_ok during the
  // address wait must be ignored.
  task automatic run_bus(input int aw, input logic [31:0] rdat);
    for (int i = 0; i < aw; i++) begin
      data_data_ok = 1'b1; data_rdata = 32'hBAD0_BAD0;
      @(posedge clk); #1;
    end
    data_data_ok = 1'b0;
    data_addr_ok = 1'b1;
    @(posedge clk); #1;
    data_addr_ok = 1'b0;
    data_data_ok = 1'b1; data_rdata = rdat;
    @(posedge clk); #1;
    data_data_ok = 1'b0; data_rdata = $urandom;
  endtask

  task automatic finish_out();
    @(posedge clk); #1;
  endtask

  initial begin
    resetn = 1'b0; in_valid = 1'b0; ea = '0; eb = '0; mem_rd = 1'b0; mem_wr = 1'b0;
    mem_size = 2'd0; mem_sext = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0;
    data_rdata = '0; out_ready = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_in_ready", {31'b0, in_ready}, 32'd0);
    check("rst_data_req", {31'b0, data_req}, 32'd0);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_data_addr", data_addr, 32'd0);
    check("rst_wstrb", {28'b0, data_wstrb}, 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;

    // Pass-through
    r0 = req_cycles;
    sb.push_back('{32'h1234_5678, 1'b0});
    issue(32'h1234_5678, 32'h0, 1'b0, 1'b0, 2'd2, 1'b0);
    @(negedge clk);
    check("pt_out_valid", {31'b0, out_valid}, 32'd1);
    finish_out();
    check("pt_no_req", req_cycles - r0, 32'd0);

    // rd and wr both set behaves as pass-through
    r0 = req_cycles;
    sb.push_back('{32'h0000_55AA, 1'b0});
    issue(32'h0000_55AA, 32'h1, 1'b1, 1'b1, 2'd0, 1'b0);
    finish_out();
    check("illegal_no_req", req_cycles - r0, 32'd0);

    // Byte store with addr_ok delayed 3 cycles
    r0 = req_cycles;
    sb.push_back('{32'h8000_0003, 1'b0});
    issue(32'h8000_0003, 32'h0000_00AB, 1'b0, 1'b1, 2'd0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) data_addr_ok = 1'b1;
      @(negedge clk);
      check("bs_req", {31'b0, data_req}, 32'd1);
      check("bs_addr", data_addr, 32'h8000_0003);
      check("bs_wdata", data_wdata, 32'hABAB_ABAB);
      check("bs_wstrb", {28'b0, data_wstrb}, 32'h8);
      check("bs_wr", {31'b0, data_wr}, 32'd1);
      @(posedge clk); #1;
    end
    data_addr_ok = 1'b0;
    data_data_ok = 1'b1;
    @(negedge clk);
    check("bs_wait_no_req", {31'b0, data_req}, 32'd0);
    @(posedge clk); #1;
    data_data_ok = 1'b0;
    finish_out();
    check("bs_req_cycles", req_cycles - r0, 32'd4);

    // Signed and unsigned half loads
    sb.push_back('{32'hFFFF_8001, 1'b0});
    issue(32'h8000_0002, 32'h0, 1'b1, 1'b0, 2'd1, 1'b1);
    @(negedge clk);
    check("hl_addr", data_addr, 32'h8000_0002);
    check("hl_wstrb", {28'b0, data_wstrb}, 32'h0);
    check("hl_wr", {31'b0, data_wr}, 32'd0);
    check("hl_size", {30'b0, data_size}, 32'd1);
    run_bus(2, 32'h8001_0000);
    finish_out();
    sb.push_back('{32'h0000_8001, 1'b0});
    issue(32'h8000_0002, 32'h0, 1'b1, 1'b0, 2'd1, 1'b0);
    run_bus(0, 32'h8001_0000);
    finish_out();

    // Signed byte load from lane 1
    sb.push_back('{32'hFFFF_FF9A, 1'b0});
    issue(32'h8000_0001, 32'h0, 1'b1, 1'b0, 2'd0, 1'b1);
    run_bus(1, 32'h0000_9A00);
    finish_out();

    // Word store and upper-half store
    sb.push_back('{32'h0000_0100, 1'b0});
    issue(32'h0000_0100, 32'hDEAD_BEEF, 1'b0, 1'b1, 2'd2, 1'b0);
    @(negedge clk);
    check("ws_wdata", data_wdata, 32'hDEAD_BEEF);
    check("ws_wstrb", {28'b0, data_wstrb}, 32'hF);
    run_bus(0, 32'h0);
    finish_out();
    sb.push_back('{32'h0000_0102, 1'b0});
    issue(32'h0000_0102, 32'hFFFF_1234, 1'b0, 1'b1, 2'd1, 1'b0);
    @(negedge clk);
    check("hs_wdata", data_wdata, 32'h1234_1234);
    check("hs_wstrb", {28'b0, data_wstrb}, 32'hC);
    run_bus(0, 32'h0);
    finish_out();

    // Back-pressure in DONE
    out_ready = 1'b0;
    sb.push_back('{32'hCAFE_F00D, 1'b0});
    issue(32'hCAFE_F00D, 32'h0, 1'b0, 1'b0, 2'd0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", {31'b0, out_valid}, 32'd1);
      check("bp_data", out_data, 32'hCAFE_F00D);
      check("bp_in_ready", {31'b0, in_ready}, 32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    finish_out();
    @(negedge clk);
    check("bp_release_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;

    // Misaligned word load
    r0 = req_cycles;
`ifdef MEM_ALIGN_CHECK_EN
    sb.push_back('{32'h8000_0006, 1'b1});
    issue(32'h8000_0006, 32'h0, 1'b1, 1'b0, 2'd2, 1'b0);
    @(negedge clk);
    check("mis_valid", {31'b0, out_valid}, 32'd1);
    finish_out();
    check("mis_no_req", req_cycles - r0, 32'd0);
`else
    sb.push_back('{32'h1122_3344, 1'b0});
    issue(32'h8000_0006, 32'h0, 1'b1, 1'b0, 2'd2, 1'b0);
    @(negedge clk);
    check("mis_addr", data_addr, 32'h8000_0004);
    run_bus(0, 32'h1122_3344);
    finish_out();
    check("mis_req_cycles", req_cycles - r0, 32'd1);
`endif

    // Reset while waiting for data, then a stray data_ok
    issue(32'h0000_0040, 32'h0, 1'b1, 1'b0, 2'd2, 1'b0);
    data_addr_ok = 1'b1;
    @(posedge clk); #1;
    data_addr_ok = 1'b0;
    resetn = 1'b0;
    @(negedge clk);
    check("wr_rst_in_ready", {31'b0, in_ready}, 32'd0);
    check("wr_rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("wr_rst_data_addr", data_addr, 32'd0);
    check("wr_rst_out_data", out_data, 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    data_data_ok = 1'b1; data_rdata = 32'h7777_7777;
    @(posedge clk); #1;
    data_data_ok = 1'b0;
    @(negedge clk);
    check("wr_stray_out_valid", {31'b0, out_valid}, 32'd0);
    check("wr_stray_in_ready", {31'b0, in_ready}, 32'd1);
    check("wr_stray_req", {31'b0, data_req}, 32'd0);
    @(posedge clk); #1;

    // A normal operation still works after the abandoned one
    sb.push_back('{32'h0000_ABCD, 1'b0});
    issue(32'h0000_ABCD, 32'h0, 1'b0, 1'b0, 2'd0, 1'b0);
    finish_out();
    repeat (2) @(posedge clk);
    #1;
    check("sb_drained", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
